prioritized_burst_arbiter: RTL and testbench

//  Shares one burst-oriented resource (bus port, memory channel) between REQUEST_WIDTH requesters.

---
 rtl/prioritized_burst_arbiter_if.sv | 39 +++
 rtl/prioritized_burst_arbiter.sv | 141 ++++++++++++++
 tb/tb_prioritized_burst_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prioritized_burst_arbiter_if.sv
// ---------------------------------------------------------------------------
// prioritized_burst_arbiter_if
//   Bundle of request/priority/done inputs and grant outputs shared between
//   the requester/resource side and the arbiter.
//   Handshake: a requester holds i_request[i] high until it is granted
//   (it may drop it earlier to withdraw). A grant is held while
//   o_grant_valid is high. It is released only by a one-cycle i_done pulse
//   from the resource; requests are not consulted while a grant is held.
//   Signals:
//     i_request       per-requester request level
//     i_priority      per-requester priority (larger = more urgent)
//     i_done          resource finished the current burst (pulse)
//     o_grant_valid   a grant is held
//     o_grant         index of current grantee
//     o_grant_onehot  one-hot of o_grant, zero when no grant is held
//   Modports: master = requester/resource side, slave = arbiter.
// ---------------------------------------------------------------------------
interface prioritized_burst_arbiter_if #(
    parameter int REQUEST_WIDTH  = 4,
    parameter int PRIORITY_WIDTH = 2,
    parameter int GRANT_WIDTH    = (REQUEST_WIDTH == 1) ? 1 : $clog2(REQUEST_WIDTH)
);
    logic [REQUEST_WIDTH-1:0]                     i_request;
    logic [REQUEST_WIDTH-1:0][PRIORITY_WIDTH-1:0] i_priority;
    logic                                         i_done;
    logic                                         o_grant_valid;
    logic [GRANT_WIDTH-1:0]                       o_grant;
    logic [REQUEST_WIDTH-1:0]                     o_grant_onehot;

    modport master (
        output i_request, i_priority, i_done,
        input  o_grant_valid, o_grant, o_grant_onehot
    );

    modport slave (
        input  i_request, i_priority, i_done,
        output o_grant_valid, o_grant, o_grant_onehot
    );
endinterface

// File: rtl/prioritized_burst_arbiter.sv
// ---------------------------------------------------------------------------
// prioritized_burst_arbiter
//   Shares one burst-oriented resource between REQUEST_WIDTH requesters.
//   Winner selection: aged requesters first, then highest priority, then
//   round robin starting after the last grantee; remaining ties go to the
//   lowest index. A grant is held until the resource pulses i_done.
//   Ports:
//     i_clk        clock
//     i_rst_n      synchronous active-low reset
//     bus          slave modport of prioritized_burst_arbiter_if
//     o_dbg_state  current FSM state (0 = IDLE, 1 = HOLD)
// ---------------------------------------------------------------------------
module prioritized_burst_arbiter #(
    parameter int REQUEST_WIDTH  = 4,
    parameter int GRANT_WIDTH    = (REQUEST_WIDTH == 1) ? 1 : $clog2(REQUEST_WIDTH),
    parameter int PRIORITY_WIDTH = 2,
    parameter int AGE_LIMIT      = 8,
    parameter int AGE_WIDTH      = $clog2(AGE_LIMIT + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    prioritized_burst_arbiter_if.slave  bus,
    output logic                        o_dbg_state
);

    localparam int KEY_WIDTH = PRIORITY_WIDTH + 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                               state_q, state_d;
    // grant_q doubles as the round-robin last-grant pointer; o_grant is only
    // meaningful while o_grant_valid is high.
    logic [GRANT_WIDTH-1:0]               grant_q, grant_d;
    logic [REQUEST_WIDTH-1:0][AGE_WIDTH-1:0] age_q, age_d;

    logic [REQUEST_WIDTH-1:0]             aged;
    logic                                 arb_event;
    logic [GRANT_WIDTH-1:0]               winner;
    logic                                 found;
    logic [KEY_WIDTH-1:0]                 best_key;
    logic [KEY_WIDTH-1:0]                 cand_key;
    logic                                 rr_bit;

    always_comb begin
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            aged[i] = (age_q[i] == AGE_WIDTH'(AGE_LIMIT));
        end
    end

    // Winner search. A strictly-greater compare while scanning upward means
    // equal keys resolve to the lowest index, which together with the
    // (i > last_grant) bit gives round robin that wraps to index 0.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        best_key = '0;
        cand_key = '0;
        rr_bit   = 1'b0;
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            rr_bit   = (REQUEST_WIDTH > 1) && (GRANT_WIDTH'(i) > grant_q);
            cand_key = {aged[i], bus.i_priority[i], rr_bit};
            if (bus.i_request[i] && (!found || (cand_key > best_key))) begin
                found    = 1'b1;
                best_key = cand_key;
                winner   = GRANT_WIDTH'(i);
            end
        end
    end

    // FSM next state. i_done re-arbitrates in the same cycle so a waiting
    // requester gets the resource with no idle bubble.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        arb_event = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.i_request) begin
                    arb_event = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.i_done) begin
                    if (|bus.i_request) begin
                        arb_event = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (arb_event) begin
            grant_d = winner;
        end
    end

    // Ages: cleared whenever a requester is idle; otherwise only change on
    // arbitration events (winner cleared, losers count up to AGE_LIMIT).
    always_comb begin
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            age_d[i] = age_q[i];
            if (!bus.i_request[i]) begin
                age_d[i] = '0;
            end else if (arb_event) begin
                if (winner == GRANT_WIDTH'(i)) begin
                    age_d[i] = '0;
                end else if (!aged[i]) begin
                    age_d[i] = age_q[i] + AGE_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            age_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            age_q   <= age_d;
        end
    end

    always_comb begin
        bus.o_grant_valid = (state_q == ST_HOLD);
        bus.o_grant       = grant_q;
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            bus.o_grant_onehot[i] = (state_q == ST_HOLD) && (grant_q == GRANT_WIDTH'(i));
        end
    end

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_prioritized_burst_arbiter.sv
module tb_prioritized_burst_arbiter;

    logic clk;
    logic rst_n;
    logic dbg_a;
    logic dbg_b;
    int   checks;
    int   errors;

    prioritized_burst_arbiter_if #(.REQUEST_WIDTH(4), .PRIORITY_WIDTH(2)) bus_a ();
    prioritized_burst_arbiter_if #(.REQUEST_WIDTH(4), .PRIORITY_WIDTH(2)) bus_b ();

    prioritized_burst_arbiter #(
        .REQUEST_WIDTH(4), .PRIORITY_WIDTH(2), .AGE_LIMIT(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a), .o_dbg_state(dbg_a)
    );

    prioritized_burst_arbiter #(
        .REQUEST_WIDTH(4), .PRIORITY_WIDTH(2), .AGE_LIMIT(2)
    ) dut_age (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b), .o_dbg_state(dbg_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus_a.i_request = 4'b1111;
        apply_reset();
        bus_a.i_request = 4'b0000;
        checks++;
        if (bus_a.o_grant_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b expected 0", bus_a.o_grant_valid);
        end
        checks++;
        if (bus_a.o_grant !== 2'd0) begin
            errors++; $display("FAIL reset_grant got %0d expected 0", bus_a.o_grant);
        end
        checks++;
        if (bus_a.o_grant_onehot !== 4'b0000) begin
            errors++; $display("FAIL reset_onehot got %b expected 0000", bus_a.o_grant_onehot);
        end
        checks++;
        if (dbg_a !== 1'b0) begin
            errors++; $display("FAIL reset_state got %0b expected 0", dbg_a);
        end
    endtask

    task automatic test_single();
        bus_a.i_request  = 4'b0100;
        bus_a.i_priority = '0;
        tick();
        checks++;
        if (bus_a.o_grant_valid !== 1'b1 || bus_a.o_grant !== 2'd2 || bus_a.o_grant_onehot !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got v=%0b g=%0d oh=%b expected v=1 g=2 oh=0100",
                     bus_a.o_grant_valid, bus_a.o_grant, bus_a.o_grant_onehot);
        end
        // Requests change while held: grant must not move.
        bus_a.i_request = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus_a.o_grant_valid !== 1'b1 || bus_a.o_grant !== 2'd2) begin
                errors++;
                $display("FAIL single_hold[%0d] got v=%0b g=%0d expected v=1 g=2",
                         k, bus_a.o_grant_valid, bus_a.o_grant);
            end
        end
        bus_a.i_request = 4'b0000;
        bus_a.i_done    = 1'b1;
        tick();
        bus_a.i_done    = 1'b0;
        checks++;
        if (bus_a.o_grant_valid !== 1'b0 || bus_a.o_grant_onehot !== 4'b0000) begin
            errors++;
            $display("FAIL single_release got v=%0b oh=%b expected v=0 oh=0000",
                     bus_a.o_grant_valid, bus_a.o_grant_onehot);
        end
    endtask

    task automatic test_priority();
        bus_a.i_request  = 4'b1111;
        bus_a.i_priority = {2'd3, 2'd1, 2'd1, 2'd0};
        tick();
        checks++;
        if (bus_a.o_grant !== 2'd3 || bus_a.o_grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL prio_first got v=%0b g=%0d expected v=1 g=3", bus_a.o_grant_valid, bus_a.o_grant);
        end
        // Five more arbitrations keep the losers below the age limit of 8.
        bus_a.i_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus_a.o_grant !== 2'd3 || bus_a.o_grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL prio_repeat[%0d] got v=%0b g=%0d expected v=1 g=3",
                         k, bus_a.o_grant_valid, bus_a.o_grant);
            end
        end
        bus_a.i_request = 4'b0000;
        tick();
        bus_a.i_done     = 1'b0;
        bus_a.i_priority = '0;
        checks++;
        if (bus_a.o_grant_valid !== 1'b0) begin
            errors++; $display("FAIL prio_release got v=%0b expected 0", bus_a.o_grant_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [5];
        exp_g = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        bus_a.i_request  = 4'b1111;
        bus_a.i_priority = '0;
        tick();
        checks++;
        if (bus_a.o_grant !== exp_g[0]) begin
            errors++; $display("FAIL rr[0] got %0d expected %0d", bus_a.o_grant, exp_g[0]);
        end
        for (int k = 1; k < 5; k++) begin
            tick();
            checks++;
            if (bus_a.o_grant !== exp_g[k-1] || bus_a.o_grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_hold[%0d] got v=%0b g=%0d expected v=1 g=%0d",
                         k, bus_a.o_grant_valid, bus_a.o_grant, exp_g[k-1]);
            end
            bus_a.i_done = 1'b1;
            tick();
            bus_a.i_done = 1'b0;
            checks++;
            if (bus_a.o_grant !== exp_g[k] || bus_a.o_grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr[%0d] got v=%0b g=%0d expected v=1 g=%0d",
                         k, bus_a.o_grant_valid, bus_a.o_grant, exp_g[k]);
            end
        end
        bus_a.i_request = 4'b0000;
        bus_a.i_done    = 1'b1;
        tick();
        bus_a.i_done    = 1'b0;
    endtask

    task automatic test_aging();
        logic [1:0] exp_g [6];
        exp_g = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
        apply_reset();
        bus_b.i_request  = 4'b0011;
        bus_b.i_priority = {2'd0, 2'd0, 2'd3, 2'd0};
        tick();
        checks++;
        if (bus_b.o_grant !== exp_g[0] || bus_b.o_grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL age[0] got v=%0b g=%0d expected v=1 g=%0d", bus_b.o_grant_valid, bus_b.o_grant, exp_g[0]);
        end
        for (int k = 1; k < 6; k++) begin
            bus_b.i_done = 1'b1;
            tick();
            bus_b.i_done = 1'b0;
            checks++;
            if (bus_b.o_grant !== exp_g[k] || bus_b.o_grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL age[%0d] got v=%0b g=%0d expected v=1 g=%0d",
                         k, bus_b.o_grant_valid, bus_b.o_grant, exp_g[k]);
            end
        end
        bus_b.i_request = 4'b0000;
        bus_b.i_done    = 1'b1;
        tick();
        bus_b.i_done    = 1'b0;
        checks++;
        if (bus_b.o_grant_valid !== 1'b0 || dbg_b !== 1'b0) begin
            errors++;
            $display("FAIL age_release got v=%0b st=%0b expected v=0 st=0", bus_b.o_grant_valid, dbg_b);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus_a.i_request = 4'b0010;
        tick();
        checks++;
        if (bus_a.o_grant !== 2'd1 || bus_a.o_grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got v=%0b g=%0d expected v=1 g=1", bus_a.o_grant_valid, bus_a.o_grant);
        end
        bus_a.i_request = 4'b0101;
        bus_a.i_done    = 1'b1;
        tick();
        bus_a.i_done    = 1'b0;
        checks++;
        if (bus_a.o_grant !== 2'd2 || bus_a.o_grant_valid !== 1'b1 || bus_a.o_grant_onehot !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_next got v=%0b g=%0d oh=%b expected v=1 g=2 oh=0100",
                     bus_a.o_grant_valid, bus_a.o_grant, bus_a.o_grant_onehot);
        end
        bus_a.i_request = 4'b0000;
        bus_a.i_done    = 1'b1;
        tick();
        checks++;
        if (bus_a.o_grant_valid !== 1'b0 || bus_a.o_grant_onehot !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_idle got v=%0b oh=%b expected v=0 oh=0000",
                     bus_a.o_grant_valid, bus_a.o_grant_onehot);
        end
        // i_done while idle with no request must not start anything.
        tick();
        bus_a.i_done = 1'b0;
        checks++;
        if (bus_a.o_grant_valid !== 1'b0 || dbg_a !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_idle got v=%0b st=%0b expected v=0 st=0", bus_a.o_grant_valid, dbg_a);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        bus_a.i_request = 4'b1000;
        tick();
        // Grantee drops its request: grant must persist without i_done.
        bus_a.i_request = 4'b0000;
        tick();
        checks++;
        if (bus_a.o_grant !== 2'd3 || bus_a.o_grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold got v=%0b g=%0d expected v=1 g=3", bus_a.o_grant_valid, bus_a.o_grant);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus_a.o_grant_valid !== 1'b0 || bus_a.o_grant_onehot !== 4'b0000 || bus_a.o_grant !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%0b g=%0d oh=%b expected v=0 g=0 oh=0000",
                     bus_a.o_grant_valid, bus_a.o_grant, bus_a.o_grant_onehot);
        end
        bus_a.i_request = 4'b1001;
        tick();
        checks++;
        if (bus_a.o_grant !== 2'd3 || bus_a.o_grant_valid !== 1'b1 || bus_a.o_grant_onehot !== 4'b1000) begin
            errors++;
            $display("FAIL mid_after got v=%0b g=%0d oh=%b expected v=1 g=3 oh=1000",
                     bus_a.o_grant_valid, bus_a.o_grant, bus_a.o_grant_onehot);
        end
        bus_a.i_request = 4'b0000;
        bus_a.i_done    = 1'b1;
        tick();
        bus_a.i_done    = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus_a.i_request  = '0;
        bus_a.i_priority = '0;
        bus_a.i_done     = 1'b0;
        bus_b.i_request  = '0;
        bus_b.i_priority = '0;
        bus_b.i_done     = 1'b0;
        tick();
        test_reset();
        test_single();
        test_priority();
        test_round_robin();
        test_aging();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
